// File: rtl/triangle_feeder.sv
// ============================================================================
// triangle_feeder: walks the index ROM, gathers three vertices per triangle and
// offers them to the rasterizer with a valid/ready handshake.
// Optional feature macro: BACKFACE_CULL_EN (drop triangles with area <= 0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module triangle_feeder #(
  parameter int NUM_TRIS    = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            new_frame,
  input  logic            tri_ready,
  output logic [8:0]      idx_addr,
  input  logic [26:0]     idx_data,
  output logic [8:0]      vtx_addr,
  input  logic [26:0]     vtx_data,
  output logic [2:0][8:0] vert1,
  output logic [2:0][8:0] vert2,
  output logic [2:0][8:0] vert3,
  output logic            valid_tri,
  output logic            obj_done,
  output logic            busy
);

  localparam int            CW   = $clog2(NUM_TRIS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_TRIS - 1);
  // Step on which the first ROM word of a request is sampled.
  localparam logic [2:0]    S_RD = 3'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_IDX = 3'd1,
    FETCH_VTX = 3'd2,
    PRESENT   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic [2:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      idx_addr_q, idx_addr_d;
  logic [8:0]      vtx_addr_q, vtx_addr_d;
  logic [17:0]     idx_q, idx_d;
  logic [2:0][8:0] vert1_q, vert1_d, vert2_q, vert2_d, vert3_q, vert3_d;
  logic            valid_q, valid_d;
  logic            advance;

`ifdef BACKFACE_CULL_EN
  logic signed [19:0] area_q, area_d;
  logic signed [9:0]  dx21, dy31, dy21, dx31;

  assign dx21 = $signed({1'b0, vert2_q[2]}) - $signed({1'b0, vert1_q[2]});
  assign dy31 = $signed({1'b0, vert3_q[1]}) - $signed({1'b0, vert1_q[1]});
  assign dy21 = $signed({1'b0, vert2_q[1]}) - $signed({1'b0, vert1_q[1]});
  assign dx31 = $signed({1'b0, vert3_q[2]}) - $signed({1'b0, vert1_q[2]});
  assign area_d = 20'(dx21) * 20'(dy31) - 20'(dy21) * 20'(dx31);
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    step_d     = step_q;
    cnt_d      = cnt_q;
    idx_addr_d = idx_addr_q;
    vtx_addr_d = vtx_addr_q;
    idx_d      = idx_q;
    vert1_d    = vert1_q;
    vert2_d    = vert2_q;
    vert3_d    = vert3_q;
    valid_d    = valid_q;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d    = FETCH_IDX;
          cnt_d      = '0;
          idx_addr_d = '0;
          step_d     = '0;
        end else begin
          start_d = new_frame;
        end
      end
      FETCH_IDX: begin
        step_d = step_q + 3'd1;
        if (step_q == S_RD) begin
          idx_d      = idx_data[26:9];
          vtx_addr_d = idx_data[8:0];
          step_d     = '0;
          state_d    = FETCH_VTX;
        end
      end
      FETCH_VTX: begin
        // Vertex addresses go out back to back; data returns S_RD steps later.
        step_d = step_q + 3'd1;
        if (step_q == 3'd0) vtx_addr_d = idx_q[8:0];
        if (step_q == 3'd1) vtx_addr_d = idx_q[17:9];
        if (step_q == S_RD)        vert1_d = vtx_data;
        if (step_q == S_RD + 3'd1) vert2_d = vtx_data;
        if (step_q == S_RD + 3'd2) vert3_d = vtx_data;
`ifdef BACKFACE_CULL_EN
        if (step_q == S_RD + 3'd4) begin
          if (area_q > 20'sd0) begin
            valid_d = 1'b1;
            state_d = PRESENT;
          end else begin
            advance = 1'b1;
          end
        end
`else
        if (step_q == S_RD + 3'd3) begin
          valid_d = 1'b1;
          state_d = PRESENT;
        end
`endif
      end
      PRESENT: begin
        if (tri_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (cnt_q == LAST) begin
        state_d = DONE;
      end else begin
        cnt_d      = cnt_q + 1'b1;
        idx_addr_d = 9'(cnt_q + 1'b1);
        step_d     = '0;
        state_d    = FETCH_IDX;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      step_q     <= '0;
      cnt_q      <= '0;
      idx_addr_q <= '0;
      vtx_addr_q <= '0;
      idx_q      <= '0;
      vert1_q    <= '0;
      vert2_q    <= '0;
      vert3_q    <= '0;
      valid_q    <= 1'b0;
`ifdef BACKFACE_CULL_EN
      area_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      idx_addr_q <= idx_addr_d;
      vtx_addr_q <= vtx_addr_d;
      idx_q      <= idx_d;
      vert1_q    <= vert1_d;
      vert2_q    <= vert2_d;
      vert3_q    <= vert3_d;
      valid_q    <= valid_d;
`ifdef BACKFACE_CULL_EN
      area_q     <= area_d;
`endif
    end
  end

  assign idx_addr  = idx_addr_q;
  assign vtx_addr  = vtx_addr_q;
  assign vert1     = vert1_q;
  assign vert2     = vert2_q;
  assign vert3     = vert3_q;
  assign valid_tri = valid_q;
  assign obj_done  = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_triangle_feeder.sv
// ============================================================================
// tb_triangle_feeder: randomized scoreboard bench for triangle_feeder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_triangle_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, new_frame, new_frame1, tri_ready;
  logic [8:0]      idx_addr, vtx_addr, idx_addr1, vtx_addr1;
  logic [26:0]     idx_data, vtx_data, idx_data1, vtx_data1;
  logic [2:0][8:0] vert1, vert2, vert3, v1b, v2b, v3b;
  logic            valid_tri, obj_done, busy, valid1, done1, busy1;

  logic [26:0] idx_rom [512];
  logic [26:0] vtx_rom [512];
  logic [80:0] exp_q [$];
  int n_tests = 0, n_fail = 0, done_cnt = 0, exp_done = 0, ready_mode = 1;

`ifdef BACKFACE_CULL_EN
  localparam int VK = 9;
`else
  localparam int VK = 8;
`endif

  triangle_feeder #(.NUM_TRIS(12), .MEM_LATENCY(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .new_frame(new_frame), .tri_ready(tri_ready),
    .idx_addr(idx_addr), .idx_data(idx_data), .vtx_addr(vtx_addr), .vtx_data(vtx_data),
    .vert1(vert1), .vert2(vert2), .vert3(vert3),
    .valid_tri(valid_tri), .obj_done(obj_done), .busy(busy));

  triangle_feeder #(.NUM_TRIS(1), .MEM_LATENCY(2)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .new_frame(new_frame1), .tri_ready(1'b1),
    .idx_addr(idx_addr1), .idx_data(idx_data1), .vtx_addr(vtx_addr1), .vtx_data(vtx_data1),
    .vert1(v1b), .vert2(v2b), .vert3(v3b),
    .valid_tri(valid1), .obj_done(done1), .busy(busy1));

  // ROMs: address sampled on an edge, word visible until the next edge.
  always @(posedge clk) begin
    idx_data  <= idx_rom[idx_addr];
    vtx_data  <= vtx_rom[vtx_addr];
    idx_data1 <= idx_rom[idx_addr1];
    vtx_data1 <= vtx_rom[vtx_addr1];
  end

  task automatic check(string name, logic [80:0] act, logic [80:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: triangle t is three vertex words looked up via its indices.
  function automatic logic [26:0] vtx_of(int t, int k);
    logic [26:0] ie;
    ie = idx_rom[t];
    return vtx_rom[ie[k*9 +: 9]];
  endfunction

  function automatic logic [80:0] tri_of(int t);
    return {vtx_of(t, 0), vtx_of(t, 1), vtx_of(t, 2)};
  endfunction

  function automatic bit shown(int t);
`ifdef BACKFACE_CULL_EN
    logic [26:0] a, b, c;
    int x1, y1, x2, y2, x3, y3;
    a = vtx_of(t, 0); b = vtx_of(t, 1); c = vtx_of(t, 2);
    x1 = int'(a[26:18]); y1 = int'(a[17:9]);
    x2 = int'(b[26:18]); y2 = int'(b[17:9]);
    x3 = int'(c[26:18]); y3 = int'(c[17:9]);
    return ((x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1)) > 0;
`else
    return t >= 0;
`endif
  endfunction

  // Monitor: pops the scoreboard on every transfer, checks holds while stalled.
  bit          prev_hold = 1'b0;
  logic [80:0] prev_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", valid_tri, 1'b1);
        check("hold_verts", {vert1, vert2, vert3}, prev_v);
      end
      if (valid_tri && tri_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tri_extra: got %h expected no transfer", {vert1, vert2, vert3});
        end else begin
          check("tri_data", {vert1, vert2, vert3}, exp_q.pop_front());
        end
      end
      prev_hold = valid_tri && !tri_ready;
      prev_v    = {vert1, vert2, vert3};
      if (obj_done) begin
        check("done_q_empty", exp_q.size(), 0);
        done_cnt++;
      end
    end
  end

  initial begin
    tri_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tri_ready = 1'($urandom_range(0, 1));
        1:       tri_ready = 1'b0;
        default: tri_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && busy; k++) tick();
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=1 expected 0");
    end
  endtask

  task automatic start_pass();
    wait_idle();
    new_frame = 1'b1;
    for (int t = 0; t < 12; t++) if (shown(t)) exp_q.push_back(tri_of(t));
    tick();
    new_frame = 1'b0;
    tick();
    check("start_busy", busy, 1'b1);
    check("start_idx", idx_addr, 9'd0);
  endtask

  task automatic finish_pass(bit strays);
    for (int k = 0; k < 3000 && busy; k++) begin
      new_frame = strays && ($urandom_range(0, 5) == 0);
      tick();
    end
    new_frame = 1'b0;
    exp_done++;
  endtask

  initial begin
    rst_n = 1'b0; new_frame = 1'b0; new_frame1 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      idx_rom[i] = 27'($urandom);
      vtx_rom[i] = 27'($urandom);
    end
    idx_rom[0] = {9'd3, 9'd2, 9'd1};
    idx_rom[1] = {9'd2, 9'd3, 9'd1};
    vtx_rom[1] = {9'd0, 9'd0, 9'd5};
    vtx_rom[2] = {9'd10, 9'd0, 9'd6};
    vtx_rom[3] = {9'd0, 9'd10, 9'd7};

    repeat (3) @(posedge clk);
    #1;
    check("rst_verts", {vert1, vert2, vert3}, 81'd0);
    check("rst_ctl", {idx_addr, vtx_addr, valid_tri, obj_done, busy}, 21'd0);
    check("rst_dut1", {valid1, done1, busy1}, 3'd0);
    rst_n = 1'b1;
    tick();

    // Single-triangle pass with tri_ready tied high: exact cycle timing.
    new_frame1 = 1'b1;
    tick();
    new_frame1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t_valid", valid1, k == VK);
      check("t_done", done1, k == VK + 1);
      if (k == 1)      check("t_busy_on", busy1, 1'b1);
      if (k == VK)     check("t_verts", {v1b, v2b, v3b}, tri_of(0));
      if (k == VK + 2) check("t_busy_off", busy1, 1'b0);
    end

    // Random back-pressure, with stray new_frame pulses while busy.
    ready_mode = 0;
    repeat (2) begin
      start_pass();
      finish_pass(1'b1);
    end

    // Long stall in PRESENT, then a single transfer.
    ready_mode = 1;
    start_pass();
    for (int k = 0; k < 40 && !valid_tri; k++) tick();
    check("stall_valid_seen", valid_tri, 1'b1);
    repeat (50) tick();
    ready_mode = 2;
    tick();
    ready_mode = 0;
    tick();
    check("after_xfer_valid", valid_tri, 1'b0);
    finish_pass(1'b0);

    // Asynchronous reset during vertex fetch aborts the pass.
    start_pass();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_verts", {vert1, vert2, vert3}, 81'd0);
    check("arst_ctl", {idx_addr, vtx_addr, valid_tri, obj_done, busy}, 21'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    start_pass();
    finish_pass(1'b1);

    check("done_count", done_cnt, exp_done);
    check("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
